// File: rtl/instruction_buffer.sv
// Circular instruction buffer: up to four thermometer-coded entries enqueued
// per cycle, up to four presented oldest-first to dispatch, with a sticky overflow flag.
module instruction_buffer #(
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic [3:0]               in_valid,
   input  logic [103:0]             in_entry,
   input  logic [2:0]               deq_count,
   output logic [3:0]               out_valid,
   output logic [103:0]             out_entry,
   output logic [$clog2(DEPTH):0]   free_slots,
   output logic [2:0]               fetch_slots,
   output logic                     overflow
);

   localparam int ENTRY_W = 26;
   localparam int PW      = $clog2(DEPTH);
   localparam int CW      = PW + 1;

   logic [ENTRY_W-1:0] mem [DEPTH];
   logic [PW-1:0]      head;
   logic [PW-1:0]      tail;
   logic [CW-1:0]      count;

   logic [2:0]    enq;
   logic          therm_ok;
   logic [CW-1:0] free_c;
   logic          accept;
   logic [CW-1:0] enq_acc;
   logic [CW-1:0] deq_eff;
   logic          err;
   logic          wr_en;

   always_comb begin
      therm_ok = 1'b1;
      enq      = 3'd0;
      case (in_valid)
         4'b0000: enq = 3'd0;
         4'b0001: enq = 3'd1;
         4'b0011: enq = 3'd2;
         4'b0111: enq = 3'd3;
         4'b1111: enq = 3'd4;
         default: therm_ok = 1'b0;
      endcase
   end

   // Acceptance uses the pre-dequeue count, so slots freed this cycle are not reused.
   assign free_c  = CW'(DEPTH) - count;
   assign accept  = (CW'(enq) <= free_c);
   assign enq_acc = accept ? CW'(enq) : '0;
   assign deq_eff = (CW'(deq_count) > count) ? count : CW'(deq_count);
   assign err     = !flush && (!therm_ok || !accept);
   assign wr_en   = !rst && !flush && therm_ok && accept;

   always_ff @(posedge clk) begin
      if (rst) begin
         head     <= '0;
         tail     <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (err) overflow <= 1'b1;
         if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
         end else begin
            head  <= head + PW'(deq_eff);
            tail  <= tail + PW'(enq_acc);
            count <= count + enq_acc - deq_eff;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int i = 0; i < 4; i++) begin
            if (in_valid[i]) mem[tail + PW'(i)] <= in_entry[ENTRY_W*i +: ENTRY_W];
         end
      end
   end

   always_comb begin
      out_valid = '0;
      out_entry = '0;
      for (int i = 0; i < 4; i++) begin
         out_valid[i] = (count > CW'(i));
         if (out_valid[i]) out_entry[ENTRY_W*i +: ENTRY_W] = mem[head + PW'(i)];
      end
   end

   assign free_slots  = free_c;
   assign fetch_slots = (free_c >= CW'(4)) ? 3'd4 : free_c[2:0];

endmodule
